// File: rtl/sme_dom_alu_pkg.sv
// sme_pkg: shared types and index helper for the DOM masked bitwise unit.
package sme_pkg;

  // Bitwise operation selector (ANDN computes rs1 & ~rs2).
  typedef enum logic [1:0] {
    SME_DOM_AND  = 2'b00,
    SME_DOM_OR   = 2'b01,
    SME_DOM_XOR  = 2'b10,
    SME_DOM_ANDN = 2'b11
  } sme_dom_op_t;

  // Control FSM states; ST_REFR is only reachable with the refresh build.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_COMP = 3'd2,
    ST_REFR = 3'd3,
    ST_DONE = 3'd4
  } sme_dom_alu_st_t;

  // Randomness word shared by the cross-domain pair (s, p); the same word
  // masks ands[s][p] and ands[p][s] so it cancels in the final recombination.
  // The diagonal (s == p) takes no randomness and returns 0.
  function automatic int sme_dom_rng_idx(input int s, input int p);
    int lo;
    int hi;
    if (s == p) begin
      return 0;
    end
    lo = (s < p) ? s : p;
    hi = (s < p) ? p : s;
    return lo + (hi * (hi - 1)) / 2;
  endfunction

endpackage

// File: rtl/sme_dom_alu_gadget.sv
// sme_dom_gadget: registered cross products and compression for share domain S.
module sme_dom_gadget
  import sme_pkg::*;
#(
  parameter int D = 3,
  parameter int N = 32,
  parameter int S = 0,
  localparam int RG = D * (D - 1) / 2
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         clr,
  input  logic         mul_en,
  input  logic         op_xor,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y [D-1:0],
  input  logic [N-1:0] rng [RG-1:0],
  output logic [N-1:0] comp
);

  logic [N-1:0] ands_r     [D-1:0];
  logic [N-1:0] ands_nxt_s [D-1:0];

  // Cross products of this domain's x share with every y share, blinded off-diagonal.
  always_comb begin
    for (int p = 0; p < D; p++) begin
      ands_nxt_s[p] = {N{1'b0}};
      if (op_xor) begin
        ands_nxt_s[p] = (p == S) ? (x ^ y[p]) : {N{1'b0}};
      end else if (p == S) begin
        ands_nxt_s[p] = x & y[p];
      end else begin
        ands_nxt_s[p] = (x & y[p]) ^ rng[sme_dom_rng_idx(S, p)];
      end
    end
  end

  // Product register: the glitch barrier between domains before compression.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || clr) begin
      for (int p = 0; p < D; p++) begin
        ands_r[p] <= {N{1'b0}};
      end
    end else if (mul_en) begin
      ands_r <= ands_nxt_s;
    end else begin
      ands_r <= ands_r;
    end
  end

  // Compression: XOR of the registered products of this domain only.
  always_comb begin
    comp = {N{1'b0}};
    for (int p = 0; p < D; p++) begin
      comp = comp ^ ands_r[p];
    end
  end

endmodule

// File: rtl/sme_dom_alu.sv
// sme_dom_alu: pipelined, handshaked DOM masked AND/OR/XOR/ANDN unit.
// Optional feature macro: SME_DOM_REFRESH_EN (adds a share-refresh stage).
module sme_dom_alu
  import sme_pkg::*;
#(
  parameter int D = 3,
  parameter int N = 32,
  localparam int RG = D * (D - 1) / 2,
`ifdef SME_DOM_REFRESH_EN
  localparam int RW = RG + D
`else
  localparam int RW = RG
`endif
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] rs1 [D-1:0],
  input  logic [N-1:0] rs2 [D-1:0],
  input  logic         rng_valid,
  output logic         rng_req,
  input  logic [N-1:0] rng [RW-1:0],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] rd [D-1:0]
);

  sme_dom_alu_st_t state_r;
  sme_dom_alu_st_t state_nxt_s;
  sme_dom_op_t     op_s;

  logic accept_s;
  logic clr_s;
  logic mul_en_s;
  logic inv_x_s;
  logic inv_y_s;
  logic in_ready_r;
  logic out_valid_r;
  logic inv_rd_r;
  logic op_xor_r;

  logic [N-1:0] x_r     [D-1:0];
  logic [N-1:0] y_r     [D-1:0];
  logic [N-1:0] rng_r   [RW-1:0];
  logic [N-1:0] rd_r    [D-1:0];
  logic [N-1:0] g_rng_s [RG-1:0];
  logic [N-1:0] comp_s  [D-1:0];

  // Next-state logic: flush beats everything, DONE exit also scrubs shares.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    clr_s       = 1'b0;
    if (flush) begin
      state_nxt_s = ST_IDLE;
      clr_s       = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && rng_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_MUL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL:  state_nxt_s = ST_COMP;
`ifdef SME_DOM_REFRESH_EN
        ST_COMP: state_nxt_s = ST_REFR;
        ST_REFR: state_nxt_s = ST_DONE;
`else
        ST_COMP: state_nxt_s = ST_DONE;
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_nxt_s = ST_IDLE;
            clr_s       = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          clr_s       = 1'b1;
        end
      endcase
    end
  end

  // State register with registered handshake flags decoded from the next state.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Operation decode: which share-0 inversions turn OR/ANDN into an AND.
  always_comb begin
    op_s    = sme_dom_op_t'(op);
    inv_x_s = (op_s == SME_DOM_OR);
    inv_y_s = (op_s == SME_DOM_OR) || (op_s == SME_DOM_ANDN);
  end

  // Share datapath: capture at accept, compress in COMP, optional refresh.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || clr_s) begin
      inv_rd_r <= 1'b0;
      op_xor_r <= 1'b0;
      for (int s = 0; s < D; s++) begin
        x_r[s]  <= {N{1'b0}};
        y_r[s]  <= {N{1'b0}};
        rd_r[s] <= {N{1'b0}};
      end
      for (int w = 0; w < RW; w++) begin
        rng_r[w] <= {N{1'b0}};
      end
    end else begin
      if (accept_s) begin
        inv_rd_r <= (op_s == SME_DOM_OR);
        op_xor_r <= (op_s == SME_DOM_XOR);
        for (int s = 0; s < D; s++) begin
          x_r[s] <= rs1[s] ^ {N{(s == 0) && inv_x_s}};
          y_r[s] <= rs2[s] ^ {N{(s == 0) && inv_y_s}};
        end
        for (int w = 0; w < RW; w++) begin
          rng_r[w] <= rng[w];
        end
      end
      if (state_r == ST_COMP) begin
        for (int s = 0; s < D; s++) begin
          rd_r[s] <= comp_s[s] ^ {N{(s == 0) && inv_rd_r}};
        end
      end
`ifdef SME_DOM_REFRESH_EN
      if (state_r == ST_REFR) begin
        for (int s = 0; s < D; s++) begin
          rd_r[s] <= rd_r[s] ^ rng_r[RG + s] ^ rng_r[RG + ((s + D - 1) % D)];
        end
      end
`endif
    end
  end

  // Gadget randomness: the first RG captured words.
  always_comb begin
    for (int w = 0; w < RG; w++) begin
      g_rng_s[w] = rng_r[w];
    end
  end

  assign mul_en_s = (state_r == ST_MUL);

  for (genvar s = 0; s < D; s++) begin : g_dom
    sme_dom_gadget #(
      .D (D),
      .N (N),
      .S (s)
    ) u_gadget (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .clr      (clr_s),
      .mul_en   (mul_en_s),
      .op_xor   (op_xor_r),
      .x        (x_r[s]),
      .y        (y_r),
      .rng      (g_rng_s),
      .comp     (comp_s[s])
    );
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign rng_req   = in_ready_r & in_valid;
  assign g_clk_req = in_valid | (state_r != ST_IDLE);
  assign rd        = rd_r;

endmodule

// File: tb/tb_sme_dom_alu.sv
// tb_sme_dom_alu: scoreboard bench for sme_dom_alu (D=3, N=32).
module tb_sme_dom_alu;

  localparam int D  = 3;
  localparam int N  = 32;
  localparam int RG = 3;
`ifdef SME_DOM_REFRESH_EN
  localparam int RW  = 6;
  localparam int LAT = 3;
`else
  localparam int RW  = 3;
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         g_resetn, g_clk_req, flush, in_valid, in_ready;
  logic         rng_valid, rng_req, out_valid, out_ready;
  logic [1:0]   op;
  logic [N-1:0] rs1 [D-1:0];
  logic [N-1:0] rs2 [D-1:0];
  logic [N-1:0] rng [RW-1:0];
  logic [N-1:0] rd  [D-1:0];

  typedef struct packed {
    logic [N-1:0]        val;
    logic [D-1:0][N-1:0] sh;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  sme_dom_alu #(.D(D), .N(N)) dut (
    .g_clk     (clk),
    .g_resetn  (g_resetn),
    .g_clk_req (g_clk_req),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rng_valid (rng_valid),
    .rng_req   (rng_req),
    .rng       (rng),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ridx(input int s, input int p);
    int lo;
    int hi;
    lo = (s < p) ? s : p;
    hi = (s < p) ? p : s;
    return lo + (hi * (hi - 1)) / 2;
  endfunction

  // Golden: unmasked result from plain bitwise ops, shares from the DOM equations.
  function automatic exp_t model(input logic [1:0] o, input logic [D-1:0][N-1:0] a_sh,
                                 input logic [D-1:0][N-1:0] b_sh, input logic [RW-1:0][N-1:0] r);
    exp_t e;
    logic [D-1:0][N-1:0] x;
    logic [D-1:0][N-1:0] y;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] acc;
    x = a_sh;
    y = b_sh;
    if (o == 2'b01) x[0] = ~x[0];
    if (o == 2'b01 || o == 2'b11) y[0] = ~y[0];
    for (int s = 0; s < D; s++) begin
      acc = '0;
      if (o == 2'b10) begin
        acc = x[s] ^ y[s];
      end else begin
        for (int p = 0; p < D; p++) begin
          acc = acc ^ (x[s] & y[p]);
          if (p != s) acc = acc ^ r[ridx(s, p)];
        end
      end
      if (o == 2'b01 && s == 0) acc = ~acc;
`ifdef SME_DOM_REFRESH_EN
      acc = acc ^ r[RG + s] ^ r[RG + ((s + D - 1) % D)];
`endif
      e.sh[s] = acc;
    end
    a = a_sh[0] ^ a_sh[1] ^ a_sh[2];
    b = b_sh[0] ^ b_sh[1] ^ b_sh[2];
    case (o)
      2'b00:   e.val = a & b;
      2'b01:   e.val = a | b;
      2'b10:   e.val = a ^ b;
      default: e.val = a & ~b;
    endcase
    return e;
  endfunction

  // Monitor: on each output handshake pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (g_resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("unmasked", rd[0] ^ rd[1] ^ rd[2], mon_e.val);
        for (int s = 0; s < D; s++) check($sformatf("share%0d", s), rd[s], mon_e.sh[s]);
      end
    end
  end

  // mode: 0 normal, 1 hold out_ready low 10 cycles, 2 flush in MUL,
  //       3 flush in DONE, 4 reset in MUL
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [D-1:0][N-1:0]  as;
    logic [D-1:0][N-1:0]  bs;
    logic [RW-1:0][N-1:0] r;
    logic [N-1:0]         snap [D-1:0];
    exp_t e;
    int   w;
    as[0] = a;
    bs[0] = b;
    for (int s = 1; s < D; s++) begin
      as[s] = $urandom;
      bs[s] = $urandom;
      as[0] = as[0] ^ as[s];
      bs[0] = bs[0] ^ bs[s];
    end
    for (int i = 0; i < RW; i++) r[i] = $urandom;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("idle_wait", 32'(in_ready), 32'd1);
    out_ready = (mode == 0 || mode == 2 || mode == 4);
    op = o;
    for (int s = 0; s < D; s++) begin
      rs1[s] = as[s];
      rs2[s] = bs[s];
    end
    for (int i = 0; i < RW; i++) rng[i] = r[i];
    in_valid  = 1'b1;
    rng_valid = 1'b1;
    sb.push_back(model(o, as, bs, r));
    tick();
    in_valid  = 1'b0;
    rng_valid = 1'b0;
    for (int s = 0; s < D; s++) begin
      rs1[s] = $urandom;
      rs2[s] = $urandom;
    end
    for (int i = 0; i < RW; i++) rng[i] = $urandom;
    if (mode == 2 || mode == 4) begin
      if (mode == 2) flush = 1'b1;
      else g_resetn = 1'b0;
      tick();
      flush    = 1'b0;
      g_resetn = 1'b1;
      e = sb.pop_back();
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      for (int s = 0; s < D; s++) check("abort_rd", rd[s], 32'd0);
      return;
    end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("latency", 32'(out_valid), 32'(k == LAT));
    end
    if (mode == 1) begin
      for (int s = 0; s < D; s++) snap[s] = rd[s];
      for (int c = 0; c < 10; c++) begin
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        for (int s = 0; s < D; s++) check("hold_rd", rd[s], snap[s]);
      end
      out_ready = 1'b1;
      tick();
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
    end else if (mode == 3) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      e = sb.pop_back();
      check("flush_done_valid", 32'(out_valid), 32'd0);
      check("flush_done_ready", 32'(in_ready), 32'd1);
      for (int s = 0; s < D; s++) check("flush_done_rd", rd[s], 32'd0);
      out_ready = 1'b1;
    end
  endtask

  localparam logic [31:0] OPA = 32'hF0F0_F0F0;
  localparam logic [31:0] OPB = 32'hFF00_FF00;

  initial begin
    g_resetn  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    rng_valid = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    for (int s = 0; s < D; s++) begin
      rs1[s] = '0;
      rs2[s] = '0;
    end
    for (int i = 0; i < RW; i++) rng[i] = '0;
    repeat (3) tick();
    g_resetn = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rng_req", 32'(rng_req), 32'd0);
    check("rst_clk_req", 32'(g_clk_req), 32'd0);
    for (int s = 0; s < D; s++) check("rst_rd", rd[s], 32'd0);
    in_valid = 1'b1;
    #1;
    check("clk_req_follow", 32'(g_clk_req), 32'd1);
    in_valid = 1'b0;

    // Directed vectors: AND, OR, XOR, ANDN on the reference operands.
    run_op(2'b00, OPA, OPB, 0);
    run_op(2'b01, OPA, OPB, 0);
    run_op(2'b10, OPA, OPB, 0);
    run_op(2'b11, OPA, OPB, 0);
    check("const_and", OPA & OPB, 32'hF000_F000);

    // No fresh randomness: nothing may be accepted.
    tick();
    tick();
    op        = 2'b00;
    in_valid  = 1'b1;
    rng_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd1);
      check("stall_rng_req", 32'(rng_req), 32'd1);
      check("stall_out_valid", 32'(out_valid), 32'd0);
      check("stall_sb", 32'(sb.size()), 32'd0);
    end
    run_op(2'b00, OPA, OPB, 0);

    // Back-pressure, flush in MUL and DONE, reset mid-operation.
    run_op(2'b00, OPA, OPB, 1);
    run_op(2'b00, OPA, OPB, 2);
    run_op(2'b00, OPA, OPB, 0);
    run_op(2'b01, OPA, OPB, 3);
    run_op(2'b00, OPA, OPB, 0);
    run_op(2'b11, OPA, OPB, 4);
    run_op(2'b00, OPA, OPB, 0);

    // Random ops, operands, shares and randomness.
    for (int i = 0; i < 1000; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 0);
    end

    repeat (4) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
